acc_drain: RTL and testbench
============================

# acc_drain

Result drain for the affine core: snapshots the dual accumulator pair (acc1/acc2) from the register file when the datapath signals a completed dual write. It queues pairs in a small FIFO and serialises each pair onto a valid/ready output stream, acc1 first, then acc2. It sits between the register file's fixed accumulator outputs and the external result consumer, which is the reader for the values the core writes.

## Interface
- DEPTH, 4: pair-FIFO depth in acc pairs; power of two, ≥2.
- N (from package affine): datapath word width; not overridable here.

- clk_i  in  1  system clock, all state on posedge.
- rst_i  in  1  asynchronous, active-high reset.
- cap_i  in  1  capture strobe: sample acc1_i/acc2_i this cycle.
- acc1_i  in  N  signed accumulator 1 (register-file acc1 output).
- acc2_i  in  N  signed accumulator 2 (register-file acc2 output).
- out_data_o  out  N  signed output word.
- out_valid_o  out  1  out_data_o is valid.
- out_ready_i  in  1  consumer accepts word.
- out_last_o  out  1  current word is acc2, the second word of a pair.
- full_o  out  1  FIFO holds DEPTH pairs.
- busy_o  out  1  FIFO non-empty or pair transmission in progress.
- ovf_o  out  1  sticky: a capture was dropped.
- ovf_clr_i  in  1  clears ovf_o.

## Operation
- Capture: on a posedge with cap_i=1 and a free slot, {acc1_i, acc2_i} is written at the write pointer. Pointer wraps mod DEPTH. The count increments unless a pop occurs in the same cycle.
- Transmit FSM, two states:
  - SEND1 presents fifo[rd].acc1 with out_last_o=0. A handshake (valid&ready) moves it to SEND2.
  - SEND2 presents fifo[rd].acc2 with out_last_o=1. A handshake pops the entry, advances rd with wrap, and returns to SEND1.
- out_valid_o = (count≠0). FIFO is show-ahead: the word is driven from registered storage, with no extra output register.
- The entry is held until its acc2 word is accepted. The acc1 word is never re-sent.
- Full: a capture with count=DEPTH and no pop in that cycle is dropped. Stored data is unchanged and ovf_o is set.
- Capture while full in the same cycle as the SEND2 handshake is accepted, because the freed slot is reused. The count stays at DEPTH.
- If ovf_clr_i and a dropped capture occur in the same cycle, ovf_o stays 1 (set wins).
- Capture and pop on an empty-after-pop FIFO in the same cycle: the new pair becomes the head in the following cycle.
- Counter width is $clog2(DEPTH+1). Pointers are $clog2(DEPTH) bits with natural wrap.
- No arithmetic is done on data. Words pass bit-exact, sign preserved.

## Timing
- Reset values:
  - out_valid_o=0, out_last_o=0, full_o=0, busy_o=0, ovf_o=0.
  - out_data_o=0, because storage is cleared.
  - FSM=SEND1, pointers and count=0.
- Capture-to-valid latency is 1 cycle. cap_i high at edge k gives out_valid_o=1 after edge k, carrying acc1.
- With out_ready_i held high, one pair occupies 2 cycles, and back-to-back pairs stream with no bubble.
- While out_valid_o=1 and out_ready_i=0, out_data_o and out_last_o must hold stable.
- out_ready_i is allowed to be high while out_valid_o=0 and has no effect then.
- rst_i mid-transfer: outputs drop to reset values asynchronously. Queued pairs are discarded, and the first post-reset word is acc1 of a new capture.
- cap_i is sampled as a level on every edge. Holding it high for k cycles captures k pairs.

## Structure
- Package affine: add typedef acc_pair_t (packed struct {logic signed [N-1:0] acc1, acc2}) and localparam ACC_FIFO_DEPTH = 4 as the default source.
- Sub-module acc_fifo: generic show-ahead FIFO of acc_pair_t with push/pop/full/empty/count. acc_drain holds the FSM, overflow logic and output mux.
- acc_drain connects to the register file's acc1/acc2 outputs. cap_i is driven one cycle after the wdual write, so the new values are visible.

## Test plan
- Single pair: cap_i for 1 cycle with acc1=0x0012, acc2=-5, ready=1 → words 0x0012 (last=0) then -5 (last=1) on consecutive cycles, then valid=0, busy=0.
- Backpressure: capture {7,9}, ready=0 for 5 cycles → data=7, valid=1, last=0 stable throughout. Ready=1 → 7 then 9 are accepted.
- Fill: DEPTH=4, ready=0, 5 captures {i, 100+i} → full_o=1 after 4 and ovf_o=1 after the 5th. Drain yields exactly 0,100,1,101,2,102,3,103.
- Full plus pop: full FIFO, in SEND2 with ready=1, capture {50,51} in the same cycle → ovf_o stays 0, full_o stays 1, and {50,51} is the last pair drained.
- Overflow clear race: ovf_clr_i=1 in the same cycle as a dropped capture → ovf_o=1. Clear alone the next cycle → ovf_o=0.
- Async reset mid-stream: 3 pairs queued, acc1 presented, assert rst_i between edges → valid/busy/full drop immediately. After release, capture {1,2} → output is 1 then 2.

Source files
------------

// File: rtl/affine_pkg.sv
// Shared types for the affine core: datapath width and the accumulator pair
// record that the result drain queues.
package affine;

    localparam int N              = 16;
    localparam int ACC_FIFO_DEPTH = 4;

    typedef struct packed {
        logic signed [N-1:0] acc1;
        logic signed [N-1:0] acc2;
    } acc_pair_t;

    typedef enum logic {
        SEND1 = 1'b0,
        SEND2 = 1'b1
    } drain_state_t;

endpackage

// File: rtl/acc_fifo.sv
// Show-ahead FIFO of accumulator pairs. The head entry is always visible on
// dout straight from storage; a push into a full FIFO succeeds if a pop frees a slot.
module acc_fifo
    import affine::*;
#(
    parameter  int DEPTH = ACC_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  acc_pair_t        din,
    output acc_pair_t        dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    acc_pair_t        mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Storage and write pointer; storage is cleared so the idle output word reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= PTR_W'(0);
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Read pointer advances on every accepted pop, wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= PTR_W'(0);
        end else if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_r <= rd_ptr_r;
        end
    end

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= CNT_W'(0);
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/acc_drain.sv
// Result drain: captures acc1/acc2 pairs into a FIFO and serialises each pair
// onto a valid/ready stream, acc1 then acc2, with a sticky drop flag.
module acc_drain
    import affine::*;
#(
    parameter int DEPTH = ACC_FIFO_DEPTH
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cap_i,
    input  logic signed [N-1:0] acc1_i,
    input  logic signed [N-1:0] acc2_i,
    output logic signed [N-1:0] out_data_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                out_last_o,
    output logic                full_o,
    output logic                busy_o,
    output logic                ovf_o,
    input  logic                ovf_clr_i
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    drain_state_t     state_r;
    logic             ovf_r;
    acc_pair_t        cap_pair_s;
    acc_pair_t        head_s;
    logic             full_s;
    logic             empty_s;
    logic [CNT_W-1:0] count_s;
    logic             hs_s;
    logic             pop_s;
    logic             drop_s;

    assign cap_pair_s.acc1 = acc1_i;
    assign cap_pair_s.acc2 = acc2_i;

    assign hs_s   = out_valid_o && out_ready_i;
    assign pop_s  = hs_s && (state_r == SEND2);
    assign drop_s = cap_i && full_s && !pop_s;

    acc_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (cap_i),
        .pop   (pop_s),
        .din   (cap_pair_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Word sequencer: an entry stays at the head until its acc2 word is taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= SEND1;
        end else begin
            case (state_r)
                SEND1:   state_r <= hs_s ? SEND2 : SEND1;
                SEND2:   state_r <= hs_s ? SEND1 : SEND2;
                default: state_r <= SEND1;
            endcase
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Output word select straight from the FIFO head.
    always_comb begin
        out_data_o = head_s.acc1;
        if (state_r == SEND2) begin
            out_data_o = head_s.acc2;
        end else begin
            out_data_o = head_s.acc1;
        end
    end

    assign out_valid_o = !empty_s;
    assign out_last_o  = (state_r == SEND2);
    assign full_o      = full_s;
    assign busy_o      = (count_s != CNT_W'(0));
    assign ovf_o       = ovf_r;

endmodule

// File: tb/tb_acc_drain.sv
// Self-checking bench for acc_drain: directed vector table, async reset
// sequence and randomized traffic against a queue-based reference model.
module tb_acc_drain;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cap = 1'b0;
    logic [15:0] a1  = 16'h0000;
    logic [15:0] a2  = 16'h0000;
    logic        rdy = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] out_data;
    logic        out_valid, out_last, full, busy, ovf;

    int n_tests = 0;
    int n_fail  = 0;

    acc_drain #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cap_i       (cap),
        .acc1_i      (a1),
        .acc2_i      (a2),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (rdy),
        .out_last_o  (out_last),
        .full_o      (full),
        .busy_o      (busy),
        .ovf_o       (ovf),
        .ovf_clr_i   (clr)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of pairs, which word of the head is on offer, drop flag.
    typedef struct {
        logic [15:0] w1;
        logic [15:0] w2;
    } pair_t;

    pair_t m_q[$];
    int    m_phase = 0;
    bit    m_ovf   = 1'b0;

    typedef struct {
        logic        cap;
        logic [15:0] a1;
        logic [15:0] a2;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [15:0] ed;
        logic        el;
        logic        ef;
        logic        eo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic c, logic [15:0] x1, logic [15:0] x2, logic r,
                                logic k, logic ev, logic [15:0] ed, logic el,
                                logic ef, logic eo);
        vec_t v;
        v.cap = c; v.a1 = x1; v.a2 = x2; v.rdy = r; v.clr = k;
        v.ev = ev; v.ed = ed; v.el = el; v.ef = ef; v.eo = eo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_phase = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_update();
        int    sz = m_q.size();
        bit    pop = 1'b0;
        bit    drop = 1'b0;
        pair_t p;
        if (sz != 0 && rdy) begin
            if (m_phase == 0) m_phase = 1;
            else begin pop = 1'b1; m_phase = 0; end
        end
        if (pop) void'(m_q.pop_front());
        if (cap) begin
            if (sz < DEPTH || pop) begin
                p.w1 = a1; p.w2 = a2;
                m_q.push_back(p);
            end else begin
                drop = 1'b1;
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic check_model(input string tag);
        bit v = (m_q.size() != 0);
        chk({tag, "_valid"}, out_valid, v);
        chk({tag, "_busy"},  busy,      v);
        chk({tag, "_full"},  full,      m_q.size() == DEPTH);
        chk({tag, "_ovf"},   ovf,       m_ovf);
        chk({tag, "_last"},  out_last,  v && m_phase == 1);
        if (v) chk({tag, "_data"}, out_data, (m_phase == 1) ? m_q[0].w2 : m_q[0].w1);
    endtask

    task automatic step(input logic c, input logic [15:0] x1, input logic [15:0] x2,
                        input logic r, input logic k);
        cap = c; a1 = x1; a2 = x2; rdy = r; clr = k;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        // Single pair
        vecs.push_back(mk(1, 16'h0012, 16'hFFFB, 1, 0, 1, 16'h0012, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 1, 16'hFFFB, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0));
        // Backpressure
        vecs.push_back(mk(1, 16'd7, 16'd9, 0, 0, 1, 16'd7, 0, 0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 16'd0, 16'd0, 0, 0, 1, 16'd7, 0, 0, 0));
        vecs.push_back(mk(0, 16'd0, 16'd0, 1, 0, 1, 16'd9, 1, 0, 0));
        vecs.push_back(mk(0, 16'd0, 16'd0, 1, 0, 0, 16'd0, 0, 0, 0));
        // Fill and overflow, then drain
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 16'(i), 16'(100 + i), 0, 0, 1, 16'd0, 0, (i == 3), 0));
        vecs.push_back(mk(1, 16'd4, 16'd104, 0, 0, 1, 16'd0, 0, 1, 1));
        vecs.push_back(mk(0, 16'd0, 16'd0, 1, 0, 1, 16'd100, 1, 1, 1));
        for (int i = 1; i < 4; i++) begin
            vecs.push_back(mk(0, 16'd0, 16'd0, 1, 0, 1, 16'(i), 0, 0, 1));
            vecs.push_back(mk(0, 16'd0, 16'd0, 1, 0, 1, 16'(100 + i), 1, 0, 1));
        end
        vecs.push_back(mk(0, 16'd0, 16'd0, 1, 0, 0, 16'd0, 0, 0, 1));
        vecs.push_back(mk(0, 16'd0, 16'd0, 0, 1, 0, 16'd0, 0, 0, 0));
        // Full plus pop: capture in the same cycle as the SEND2 handshake
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 16'(10 + i), 16'(20 + i), 0, 0, 1, 16'd10, 0, (i == 3), 0));
        vecs.push_back(mk(0, 16'd0, 16'd0, 1, 0, 1, 16'd20, 1, 1, 0));
        vecs.push_back(mk(1, 16'd50, 16'd51, 1, 0, 1, 16'd11, 0, 1, 0));
        vecs.push_back(mk(0, 16'd0, 16'd0, 1, 0, 1, 16'd21, 1, 1, 0));
        vecs.push_back(mk(0, 16'd0, 16'd0, 1, 0, 1, 16'd12, 0, 0, 0));
        vecs.push_back(mk(0, 16'd0, 16'd0, 1, 0, 1, 16'd22, 1, 0, 0));
        vecs.push_back(mk(0, 16'd0, 16'd0, 1, 0, 1, 16'd13, 0, 0, 0));
        vecs.push_back(mk(0, 16'd0, 16'd0, 1, 0, 1, 16'd23, 1, 0, 0));
        vecs.push_back(mk(0, 16'd0, 16'd0, 1, 0, 1, 16'd50, 0, 0, 0));
        vecs.push_back(mk(0, 16'd0, 16'd0, 1, 0, 1, 16'd51, 1, 0, 0));
        vecs.push_back(mk(0, 16'd0, 16'd0, 1, 0, 0, 16'd0, 0, 0, 0));
        // Overflow clear race, then leave three pairs queued with acc1 on offer
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 16'd1, 16'd2, 0, 0, 1, 16'd1, 0, (i == 3), 0));
        vecs.push_back(mk(1, 16'd9, 16'd9, 0, 1, 1, 16'd1, 0, 1, 1));
        vecs.push_back(mk(0, 16'd0, 16'd0, 0, 1, 1, 16'd1, 0, 1, 0));
        vecs.push_back(mk(0, 16'd0, 16'd0, 1, 0, 1, 16'd2, 1, 1, 0));
        vecs.push_back(mk(0, 16'd0, 16'd0, 1, 0, 1, 16'd1, 0, 0, 0));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_last",  out_last,  1'b0);
        chk("rst_full",  full,      1'b0);
        chk("rst_busy",  busy,      1'b0);
        chk("rst_ovf",   ovf,       1'b0);
        chk("rst_data",  out_data,  16'h0000);
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].cap, vecs[i].a1, vecs[i].a2, vecs[i].rdy, vecs[i].clr);
            chk($sformatf("v%0d_valid", i), out_valid, vecs[i].ev);
            chk($sformatf("v%0d_busy", i),  busy,      vecs[i].ev);
            chk($sformatf("v%0d_last", i),  out_last,  vecs[i].el);
            chk($sformatf("v%0d_full", i),  full,      vecs[i].ef);
            chk($sformatf("v%0d_ovf", i),   ovf,       vecs[i].eo);
            if (vecs[i].ev) chk($sformatf("v%0d_data", i), out_data, vecs[i].ed);
            check_model($sformatf("v%0d_m", i));
        end

        // Async reset between edges with three pairs queued
        cap = 1'b0; rdy = 1'b0; clr = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_busy",  busy,      1'b0);
        chk("arst_full",  full,      1'b0);
        chk("arst_last",  out_last,  1'b0);
        chk("arst_data",  out_data,  16'h0000);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1, 16'd1, 16'd2, 1, 0);
        chk("post_rst_w1", out_data, 16'd1);
        chk("post_rst_l1", out_last, 1'b0);
        step(0, 16'd0, 16'd0, 1, 0);
        chk("post_rst_w2", out_data, 16'd2);
        chk("post_rst_l2", out_last, 1'b1);
        step(0, 16'd0, 16'd0, 1, 0);
        chk("post_rst_idle", out_valid, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 1) == 1), 16'($urandom), 16'($urandom),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0));
            check_model("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
